lvds_align_ctrl: RTL and testbench

- Word-alignment sequencer for the soft-LVDS SGMII receive path. Sits between the 8b/10b decoder outputs and the LVDS receiver bit-slip input, in the recovered core-clock domain.
- Waits for PLL lock, hunts for K28.5 commas, and pulses bit-slip until the comma lands on the word boundary. Declares sync after consecutive good commas and drops sync on excessive code errors.
- Output o_Aligned gates the PCS sync state machine.

---
 rtl/lvds_align_pkg.sv | 29 ++
 rtl/lvds_align_window.sv | 58 +++++
 rtl/lvds_align_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_lvds_align_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_align_pkg.sv
// Shared definitions for the soft-LVDS word-alignment sequencer: state
// encodings, the K28.5 comma byte and helpers for counter sizing and comma
// detection.
package lvds_align_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_LOCK = 4'd0,
        ST_SETTLE    = 4'd1,
        ST_HUNT      = 4'd2,
        ST_SLIP      = 4'd3,
        ST_ACQUIRE   = 4'd4,
        ST_ALIGNED   = 4'd5
    } align_state_e;

    localparam logic [7:0] K28_5 = 8'hBC;

    // Bits needed for a counter that must be able to hold max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

    // A comma is a clean K28.5; an errored K28.5 counts only as an error.
    function automatic logic is_comma(input logic [7:0] code,
                                      input logic       ctrl,
                                      input logic       invalid);
        return ctrl && (code == K28_5) && !invalid;
    endfunction

endpackage

// File: rtl/lvds_align_window.sv
// Observation window shared by HUNT, ACQUIRE and ALIGNED. Counts WINDOW_CYC
// cycles, tracks whether a comma was seen and keeps a saturating code-error
// count. The comma flag and error count outputs already include the current
// cycle's inputs, so the FSM can judge the window on its final cycle.
module lvds_align_window
    import lvds_align_pkg::*;
#(
    parameter int WINDOW_CYC = 64,
    parameter int LOSS_ERRS  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic                          comma,
    input  logic                          code_err,
    output logic                          win_end,
    output logic                          comma_seen,
    output logic [cnt_w(LOSS_ERRS)-1:0]   err_count
);

    localparam int WCW = cnt_w(WINDOW_CYC);
    localparam int ECW = cnt_w(LOSS_ERRS);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYC - 1);
    localparam logic [ECW-1:0] ERR_MAX  = ECW'(LOSS_ERRS);

    logic [WCW-1:0] win_cnt_r;
    logic           comma_seen_r;
    logic [ECW-1:0] err_cnt_r;

    // Window-end strobe and running totals including this cycle's inputs.
    always_comb begin
        win_end    = run && (win_cnt_r == WIN_LAST);
        comma_seen = comma_seen_r || comma;
        if (code_err && (err_cnt_r != ERR_MAX)) begin
            err_count = err_cnt_r + ECW'(1'b1);
        end else begin
            err_count = err_cnt_r;
        end
    end

    // Window state: held at its start when idle, restarted after the last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_cnt_r    <= '0;
            comma_seen_r <= 1'b0;
            err_cnt_r    <= '0;
        end else if (!run || win_end) begin
            win_cnt_r    <= '0;
            comma_seen_r <= 1'b0;
            err_cnt_r    <= '0;
        end else begin
            win_cnt_r    <= win_cnt_r + WCW'(1'b1);
            comma_seen_r <= comma_seen;
            err_cnt_r    <= err_count;
        end
    end

endmodule

// File: rtl/lvds_align_ctrl.sv
// Word-alignment sequencer for the soft-LVDS SGMII receive path. Waits for PLL
// lock, hunts for K28.5 commas, requests bit slips until the comma sits on the
// word boundary, and declares/drops alignment based on windowed comma and
// code-error statistics.
// Optional build macro LVDS_ALIGN_STATS_EN adds slip and loss-of-sync counters.
module lvds_align_ctrl
    import lvds_align_pkg::*;
#(
    parameter int SLIP_PULSE_W = 2,
    parameter int SETTLE_CYC   = 16,
    parameter int WINDOW_CYC   = 64,
    parameter int ACQ_COMMAS   = 4,
    parameter int LOSS_ERRS    = 4,
    parameter int MAX_SLIPS    = 10
) (
    input  logic        i_CoreClk,
    input  logic        i_Rst,
    input  logic        i_PllLocked,
    input  logic [7:0]  i8_RxCodeGroup,
    input  logic        i_RxCodeCtrl,
    input  logic        i_RxCodeInvalid,
    output logic        o_RxBitSlip,
    output logic        o_Aligned,
    output logic        o_AlignFail,
    output logic [3:0]  o4_State
`ifdef LVDS_ALIGN_STATS_EN
    ,
    output logic [15:0] o16_SlipCount,
    output logic [7:0]  o8_LossCount
`endif
);

    localparam int PW = cnt_w(SLIP_PULSE_W);
    localparam int SW = cnt_w(SETTLE_CYC);
    localparam int GW = cnt_w(ACQ_COMMAS);
    localparam int MW = cnt_w(MAX_SLIPS);
    localparam int EW = cnt_w(LOSS_ERRS);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(SLIP_PULSE_W - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [GW-1:0] GOOD_LAST   = GW'(ACQ_COMMAS - 1);
    localparam logic [MW-1:0] SLIP_LAST   = MW'(MAX_SLIPS - 1);
    localparam logic [EW-1:0] ERR_LIM     = EW'(LOSS_ERRS);

    align_state_e   state_r, state_nxt_s;
    logic [PW-1:0]  pulse_cnt_r;
    logic [SW-1:0]  settle_cnt_r;
    logic [GW-1:0]  good_cnt_r;
    logic [MW-1:0]  slip_cnt_r;
    logic           bitslip_r, aligned_r, align_fail_r;

    logic           comma_s, win_run_s, win_end_s, comma_seen_s, win_good_s, slip_done_s;
    logic [EW-1:0]  err_count_s;

    assign comma_s   = is_comma(i8_RxCodeGroup, i_RxCodeCtrl, i_RxCodeInvalid);
    assign win_run_s = (state_r == ST_HUNT) || (state_r == ST_ACQUIRE) || (state_r == ST_ALIGNED);

    lvds_align_window #(
        .WINDOW_CYC (WINDOW_CYC),
        .LOSS_ERRS  (LOSS_ERRS)
    ) u_window (
        .clk        (i_CoreClk),
        .rst        (i_Rst),
        .run        (win_run_s),
        .comma      (comma_s),
        .code_err   (i_RxCodeInvalid),
        .win_end    (win_end_s),
        .comma_seen (comma_seen_s),
        .err_count  (err_count_s)
    );

    assign win_good_s  = comma_seen_s && (err_count_s < ERR_LIM);
    assign slip_done_s = (state_r == ST_SLIP) && (state_nxt_s == ST_SETTLE);

    // FSM state register.
    always_ff @(posedge i_CoreClk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= ST_WAIT_LOCK;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; losing PLL lock overrides every other transition.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_WAIT_LOCK: begin
                if (i_PllLocked) state_nxt_s = ST_SETTLE;
                else             state_nxt_s = ST_WAIT_LOCK;
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LAST) state_nxt_s = ST_HUNT;
                else                             state_nxt_s = ST_SETTLE;
            end
            ST_HUNT: begin
                if (win_end_s) state_nxt_s = win_good_s ? ST_ACQUIRE : ST_SLIP;
                else           state_nxt_s = ST_HUNT;
            end
            ST_SLIP: begin
                if (pulse_cnt_r == PULSE_LAST) state_nxt_s = ST_SETTLE;
                else                           state_nxt_s = ST_SLIP;
            end
            ST_ACQUIRE: begin
                if (!win_end_s)                    state_nxt_s = ST_ACQUIRE;
                else if (!win_good_s)              state_nxt_s = ST_SLIP;
                else if (good_cnt_r == GOOD_LAST)  state_nxt_s = ST_ALIGNED;
                else                               state_nxt_s = ST_ACQUIRE;
            end
            ST_ALIGNED: begin
                if (win_end_s && !win_good_s) state_nxt_s = ST_HUNT;
                else                          state_nxt_s = ST_ALIGNED;
            end
            default: state_nxt_s = ST_WAIT_LOCK;
        endcase
        if ((state_r != ST_WAIT_LOCK) && !i_PllLocked) begin
            state_nxt_s = ST_WAIT_LOCK;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Per-state counters: settle delay, slip pulse width, good windows, slips tried.
    always_ff @(posedge i_CoreClk or posedge i_Rst) begin
        if (i_Rst) begin
            settle_cnt_r <= '0;
            pulse_cnt_r  <= '0;
            good_cnt_r   <= '0;
            slip_cnt_r   <= '0;
        end else begin
            if ((state_r == ST_SETTLE) && (state_nxt_s == ST_SETTLE)) settle_cnt_r <= settle_cnt_r + SW'(1'b1);
            else                                                       settle_cnt_r <= '0;

            if ((state_r == ST_SLIP) && (state_nxt_s == ST_SLIP)) pulse_cnt_r <= pulse_cnt_r + PW'(1'b1);
            else                                                   pulse_cnt_r <= '0;

            if (state_nxt_s != ST_ACQUIRE) good_cnt_r <= '0;
            else if (state_r == ST_HUNT)   good_cnt_r <= GW'(1'b1);
            else if (win_end_s)            good_cnt_r <= good_cnt_r + GW'(1'b1);
            else                           good_cnt_r <= good_cnt_r;

            if (!i_PllLocked)                   slip_cnt_r <= '0;
            else if (slip_done_s)               slip_cnt_r <= (slip_cnt_r == SLIP_LAST) ? '0 : slip_cnt_r + MW'(1'b1);
            else if (state_nxt_s == ST_ALIGNED) slip_cnt_r <= '0;
            else                                slip_cnt_r <= slip_cnt_r;
        end
    end

    // Registered outputs, decoded from the next state so they change with it.
    always_ff @(posedge i_CoreClk or posedge i_Rst) begin
        if (i_Rst) begin
            bitslip_r    <= 1'b0;
            aligned_r    <= 1'b0;
            align_fail_r <= 1'b0;
        end else begin
            bitslip_r    <= (state_nxt_s == ST_SLIP);
            aligned_r    <= (state_nxt_s == ST_ALIGNED);
            align_fail_r <= slip_done_s && (slip_cnt_r == SLIP_LAST);
        end
    end

    assign o_RxBitSlip = bitslip_r;
    assign o_Aligned   = aligned_r;
    assign o_AlignFail = align_fail_r;
    assign o4_State    = state_r;

`ifdef LVDS_ALIGN_STATS_EN
    logic [15:0] slip_total_r;
    logic [7:0]  loss_total_r;

    // Lifetime statistics; only a hard reset clears them, PLL loss does not.
    always_ff @(posedge i_CoreClk or posedge i_Rst) begin
        if (i_Rst) begin
            slip_total_r <= 16'h0000;
            loss_total_r <= 8'h00;
        end else begin
            if (slip_done_s && (slip_total_r != 16'hFFFF)) slip_total_r <= slip_total_r + 16'h0001;
            else                                           slip_total_r <= slip_total_r;
            if ((state_r == ST_ALIGNED) && (state_nxt_s == ST_HUNT) && (loss_total_r != 8'hFF))
                loss_total_r <= loss_total_r + 8'h01;
            else
                loss_total_r <= loss_total_r;
        end
    end

    assign o16_SlipCount = slip_total_r;
    assign o8_LossCount  = loss_total_r;
`endif

endmodule

// File: tb/tb_lvds_align_ctrl.sv
// Self-checking bench for lvds_align_ctrl with default parameters. Directed
// scenarios push expected pulse timings into scoreboard queues; a negedge
// monitor pops and compares them as the DUT produces pulses.
module tb_lvds_align_ctrl;

    localparam int M_DATA = 0, M_COMMA = 1, M_ERR = 2, M_INV = 3;
    typedef struct { int rise; int width; } pulse_t;

    logic       clk = 1'b0, rst = 1'b1, locked = 1'b0;
    logic [7:0] code = 8'h50;
    logic       ctrl = 1'b0, invalid = 1'b0;
    logic       bitslip, aligned, align_fail;
    logic [3:0] state;
`ifdef LVDS_ALIGN_STATS_EN
    logic [15:0] slip_count;
    logic [7:0]  loss_count;
`endif

    int errors = 0, checks = 0, cyc = 0, mode = M_DATA;
    int slip_seen = 0, fail_seen = 0, arise_seen = 0;
    pulse_t exp_slip_q[$];
    int     exp_fail_q[$];
    int     exp_arise_q[$];
    int     exp_afall_q[$];

    lvds_align_ctrl dut (
        .i_CoreClk       (clk),
        .i_Rst           (rst),
        .i_PllLocked     (locked),
        .i8_RxCodeGroup  (code),
        .i_RxCodeCtrl    (ctrl),
        .i_RxCodeInvalid (invalid),
        .o_RxBitSlip     (bitslip),
        .o_Aligned       (aligned),
        .o_AlignFail     (align_fail),
        .o4_State        (state)
`ifdef LVDS_ALIGN_STATS_EN
        ,
        .o16_SlipCount   (slip_count),
        .o8_LossCount    (loss_count)
`endif
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_slip(input int rise, input int width);
        pulse_t p;
        p.rise = rise;
        p.width = width;
        exp_slip_q.push_back(p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        locked = 1'b0;
        mode = M_DATA;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        slip_seen = 0;
        fail_seen = 0;
        arise_seen = 0;
    endtask

    // Input stream: comma every 20 cycles in comma mode, otherwise per mode.
    initial begin : stream
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            k = (k == 19) ? 0 : k + 1;
            case (mode)
                M_COMMA: begin
                    code = (k == 0) ? 8'hBC : 8'h50;
                    ctrl = (k == 0);
                    invalid = 1'b0;
                end
                M_ERR:   begin code = 8'hBC; ctrl = 1'b1; invalid = 1'b1; end
                M_INV:   begin code = 8'h00; ctrl = 1'b0; invalid = 1'b1; end
                default: begin code = 8'h50; ctrl = 1'b0; invalid = 1'b0; end
            endcase
        end
    end

    // Monitor: compares observed pulse edges with the scoreboard queues.
    initial begin : monitor
        logic ps, pf, pa;
        int srise, frise, e_int;
        pulse_t e;
        ps = 1'b0; pf = 1'b0; pa = 1'b0; srise = 0; frise = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bitslip && !ps) begin slip_seen++; srise = cyc; end
                if (!bitslip && ps) begin
                    check("slip_expected", 32'(exp_slip_q.size() > 0), 32'd1);
                    if (exp_slip_q.size() > 0) begin
                        e = exp_slip_q.pop_front();
                        check("slip_rise_cycle", srise, e.rise);
                        check("slip_width", cyc - srise, e.width);
                    end
                end
                if (align_fail && !pf) begin
                    fail_seen++;
                    frise = cyc;
                    check("fail_expected", 32'(exp_fail_q.size() > 0), 32'd1);
                    if (exp_fail_q.size() > 0) begin
                        e_int = exp_fail_q.pop_front();
                        check("fail_rise_cycle", cyc, e_int);
                    end
                end
                if (!align_fail && pf) check("fail_width", cyc - frise, 1);
                if (aligned && !pa) begin
                    arise_seen++;
                    check("align_rise_expected", 32'(exp_arise_q.size() > 0), 32'd1);
                    if (exp_arise_q.size() > 0) begin
                        e_int = exp_arise_q.pop_front();
                        check("align_rise_cycle", cyc, e_int);
                    end
                end
                if (!aligned && pa) begin
                    check("align_fall_expected", 32'(exp_afall_q.size() > 0), 32'd1);
                    if (exp_afall_q.size() > 0) begin
                        e_int = exp_afall_q.pop_front();
                        check("align_fall_cycle", cyc, e_int);
                    end
                end
            end
            ps = bitslip; pf = align_fail; pa = aligned;
        end
    end

    initial begin : main
        int c0, c1, a, b;
        // Reset state
        #1;
        check("rst_bitslip", bitslip, 0);
        check("rst_aligned", aligned, 0);
        check("rst_fail", align_fail, 0);
        check("rst_state", state, 0);
        do_reset();
        repeat (5) @(negedge clk);
        check("nolock_state", state, 0);

        // Clean alignment, then tolerated and fatal error bursts
        mode = M_COMMA;
        @(posedge clk); #1; locked = 1'b1; c0 = cyc;
        exp_arise_q.push_back(c0 + 273);
        for (int i = 0; i < 400 && !aligned; i++) @(negedge clk);
        #1;
        check("clean_aligned", aligned, 1);
        check("clean_state", state, 5);
        check("clean_no_slip", slip_seen, 0);
        check("clean_arise_q", exp_arise_q.size(), 0);
        a = cyc;
        mode = M_ERR;
        repeat (3) @(posedge clk);
        #2; mode = M_COMMA;
        while (cyc < a + 64) @(negedge clk);
        check("three_errs_hold", aligned, 1);
        b = cyc;
        exp_afall_q.push_back(b + 64);
        mode = M_ERR;
        repeat (4) @(posedge clk);
        #2; mode = M_COMMA;
        for (int i = 0; i < 150 && aligned; i++) @(negedge clk);
        #1;
        check("loss_aligned", aligned, 0);
        check("loss_state", state, 2);
        check("loss_afall_q", exp_afall_q.size(), 0);
`ifdef LVDS_ALIGN_STATS_EN
        check("loss_count", loss_count, 1);
        check("loss_slip_count", slip_count, 0);
`endif

        // Misaligned: invalid codes for 3 slips, commas afterwards
        do_reset();
        mode = M_INV;
        @(posedge clk); #1; locked = 1'b1; c0 = cyc;
        for (int k = 0; k < 3; k++) push_slip(c0 + 81 + 82 * k, 2);
        for (int i = 0; i < 400 && slip_seen < 3; i++) @(negedge clk);
        check("mis_three_slips", slip_seen, 3);
        mode = M_COMMA;
        exp_arise_q.push_back(c0 + 245 + 274);
        for (int i = 0; i < 400 && !aligned; i++) @(negedge clk);
        #1;
        check("mis_aligned", aligned, 1);
        check("mis_state", state, 5);
        check("mis_slip_total", slip_seen, 3);
        check("mis_slip_q", exp_slip_q.size(), 0);
        check("mis_arise_q", exp_arise_q.size(), 0);
`ifdef LVDS_ALIGN_STATS_EN
        check("mis_slip_count", slip_count, 3);
`endif

        // No commas: ten slips, fail pulse, hunt restarts
        do_reset();
        mode = M_DATA;
        @(posedge clk); #1; locked = 1'b1; c0 = cyc;
        for (int k = 0; k < 11; k++) push_slip(c0 + 81 + 82 * k, 2);
        exp_fail_q.push_back(c0 + 81 + 82 * 9 + 2);
        for (int i = 0; i < 1100 && slip_seen < 11; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        check("nocomma_slips", slip_seen, 11);
        check("nocomma_slip_q", exp_slip_q.size(), 0);
        check("nocomma_fail_q", exp_fail_q.size(), 0);
        check("nocomma_fail_count", fail_seen, 1);
        check("nocomma_never_aligned", arise_seen, 0);
        check("nocomma_aligned", aligned, 0);
`ifdef LVDS_ALIGN_STATS_EN
        check("nocomma_slip_count", slip_count, 11);
`endif

        // PLL drop during a slip pulse, then relock
        do_reset();
        mode = M_DATA;
        @(posedge clk); #1; locked = 1'b1; c0 = cyc;
        push_slip(c0 + 81, 1);
        for (int i = 0; i < 200 && !bitslip; i++) @(negedge clk);
        check("pll_slip_active", bitslip, 1);
        locked = 1'b0;
        @(negedge clk);
        check("pll_drop_bitslip", bitslip, 0);
        check("pll_drop_state", state, 0);
        locked = 1'b1; c1 = cyc;
        @(negedge clk);
        check("relock_state", state, 1);
        push_slip(c1 + 81, 2);
        for (int i = 0; i < 200 && slip_seen < 2; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        check("relock_slips", slip_seen, 2);
        check("relock_slip_q", exp_slip_q.size(), 0);

        // Asynchronous reset in the middle of ACQUIRE
        do_reset();
        mode = M_COMMA;
        @(posedge clk); #1; locked = 1'b1;
        for (int i = 0; i < 300 && state != 4'd4; i++) @(negedge clk);
        check("acq_reached", state, 4);
        #2; rst = 1'b1; #1;
        check("async_bitslip", bitslip, 0);
        check("async_aligned", aligned, 0);
        check("async_fail", align_fail, 0);
        check("async_state", state, 0);
`ifdef LVDS_ALIGN_STATS_EN
        check("async_slip_count", slip_count, 0);
        check("async_loss_count", loss_count, 0);
`endif
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
